// File: rtl/cpu6_lsu_pkg.sv
// cpu6_lsu_pkg
// Shared types and constants for the cpu6 load/store sequencing controller.
//   lsu_state_t      : 2-bit FSM state encoding (IDLE=0, REQ=1, WAIT_RSP=2, DONE=3)
//   LSU_TIMEOUT_CYC  : default response timeout in WAIT_RSP cycles
//   LSU_TIMER_W      : width of the response watchdog counter
//   word_aligned()   : true when an address points at a 32-bit word boundary
package cpu6_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } lsu_state_t;

  localparam int LSU_TIMEOUT_CYC = 255;
  localparam int LSU_TIMER_W     = 16;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/cpu6_lsu_wdog.sv
// cpu6_lsu_wdog
// 16-bit saturating cycle counter used as the bus response watchdog.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset, clears the count
//   clr     : synchronous clear (takes priority over en)
//   en      : count this cycle
//   limit   : count value at which the watchdog expires
//   expired : combinational; high in the enabled cycle whose count reaches limit
module cpu6_lsu_wdog
  import cpu6_lsu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic [LSU_TIMER_W-1:0] limit,
  output logic                   expired
);

  logic [LSU_TIMER_W-1:0] cnt;
  logic [LSU_TIMER_W-1:0] cnt_inc;

  // Saturate at all-ones so a very long wait never wraps back to a small value.
  assign cnt_inc = (cnt == {LSU_TIMER_W{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_inc;
    end
  end

  // The current enabled cycle is included in the count, so with limit = N the
  // watchdog fires in the N-th enabled cycle after a clear.
  assign expired = en && (cnt_inc == limit);

endmodule

// File: rtl/cpu6_lsu_ctl.sv
// cpu6_lsu_ctl
// MEM-stage load/store sequencer for the cpu6 pipeline. Turns a decoded lw/sw
// into one word transaction on the data bus, stalls the pipeline until it
// finishes, and reports misaligned accesses and response timeouts.
//
// Ports
//   clk, reset                 : clock and synchronous active-high reset
//   mem_rd, mem_wr             : MEM-stage lw / sw (read wins if both are high)
//   mem_addr, mem_wdata        : effective address and store data
//   flush                      : kill the MEM-stage instruction
//   stall                      : hold IF..MEM (combinational in IDLE)
//   ld_valid, ld_data          : one-cycle load result for WB
//   misalign                   : one-cycle pulse for a non-word-aligned op
//   bus_err                    : one-cycle pulse for a response timeout
//   req_valid/ready/we/addr/wdata : bus request channel
//   rsp_valid, rsp_rdata       : bus response (no back-pressure)
//   dbg_state                  : current FSM state (lsu_state_t encoding)
//
// Request handshake: a transfer happens on a rising edge where req_valid and
// req_ready are both high. Once req_valid rises it stays high, and req_we,
// req_addr and req_wdata stay constant, until that transfer happens; req_ready
// may depend on req_valid. The response channel has no ready: rsp_valid is
// taken in the WAIT_RSP cycle it appears and ignored in every other state.
module cpu6_lsu_ctl
  import cpu6_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = LSU_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [LSU_TIMER_W-1:0] TIMEOUT_LIM = LSU_TIMER_W'(TIMEOUT_CYC);

  lsu_state_t state;
  lsu_state_t next_state;

  logic op;
  logic aligned;
  logic start;
  logic kill_q;
  logic err_q;
  logic wd_clr;
  logic wd_en;
  logic wd_expired;

  assign op      = mem_rd | mem_wr;
  assign aligned = word_aligned(mem_addr);
  // A killed op in IDLE is dropped entirely: no request, no misalign report.
  assign start   = (state == ST_IDLE) && op && !flush && aligned;

  // Timer restarts on acceptance and only runs while waiting for the response.
  assign wd_clr = (state == ST_REQ) && req_ready;
  assign wd_en  = (state == ST_WAIT_RSP);

  cpu6_lsu_wdog u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .limit   (TIMEOUT_LIM),
    .expired (wd_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (start) next_state = ST_REQ;
      ST_REQ:      if (req_ready) next_state = ST_WAIT_RSP;
      ST_WAIT_RSP: if (rsp_valid || wd_expired) next_state = ST_DONE;
      // DONE always returns to IDLE so the retiring instruction is never
      // re-evaluated; the next op is looked at fresh in IDLE.
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_valid = (state == ST_REQ);
    stall     = 1'b0;
    case (state)
      ST_IDLE:     stall = start;
      ST_REQ:      stall = 1'b1;
      ST_WAIT_RSP: stall = 1'b1;
      ST_DONE:     stall = 1'b0;
      default:     stall = 1'b0;
    endcase
    misalign  = (state == ST_IDLE) && op && !flush && !aligned;
    ld_valid  = (state == ST_DONE) && !req_we && !kill_q && !err_q;
    bus_err   = (state == ST_DONE) && err_q && !kill_q;
    dbg_state = state;
  end

  // Request registers: captured once when the op is taken, then frozen
  // through REQ so the bus sees a stable request until it accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (start) begin
      req_we    <= !mem_rd;
      req_addr  <= mem_addr;
      req_wdata <= mem_wdata;
    end
  end

  // Response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_data <= '0;
    end else if ((state == ST_WAIT_RSP) && rsp_valid) begin
      ld_data <= rsp_rdata;
    end
  end

  // Kill and error flags live for one access; DONE always leads into IDLE,
  // so clearing them in DONE clears them on entry to IDLE. A flush never
  // aborts the bus transaction, it only hides the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      kill_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state == ST_DONE) begin
      kill_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (((state == ST_REQ) || (state == ST_WAIT_RSP)) && flush) begin
        kill_q <= 1'b1;
      end
      // A response arriving in the expiry cycle wins over the timeout.
      if ((state == ST_WAIT_RSP) && !rsp_valid && wd_expired) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu6_lsu_ctl.sv
// tb_cpu6_lsu_ctl
// Directed bench for cpu6_lsu_ctl: the stimulus pushes expected bus requests
// and expected result events into queues; monitors on the falling edge pop
// and compare them whenever the DUT presents a request or a result pulse.
module tb_cpu6_lsu_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd, mem_wr, flush;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall, ld_valid, misalign, bus_err;
  logic [31:0] ld_data;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  cpu6_lsu_ctl #(.TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .flush     (flush),
    .stall     (stall),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Result events: {kind, data}; kind 1 = load data, 2 = misalign (addr), 3 = bus_err
  logic [33:0] exp_q[$];
  // Bus requests: {we, addr, wdata}
  logic [64:0] exp_req_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [64:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected output %h, expected nothing (t=%0t)", name, act, $time);
  endtask

  task automatic pop_cmp(input string name, input logic [33:0] act);
    if (exp_q.size() == 0) fail_unexpected(name, 65'(act));
    else check(name, 65'(act), 65'(exp_q.pop_front()));
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (ld_valid) pop_cmp("ld_valid", {2'd1, ld_data});
    if (misalign) pop_cmp("misalign", {2'd2, mem_addr});
    if (bus_err)  pop_cmp("bus_err",  {2'd3, 32'd0});
  end

  // Every cycle with req_valid high is compared against the head request,
  // which also proves the request fields stay stable until acceptance.
  always @(negedge clk) begin
    if (req_valid) begin
      if (exp_req_q.size() == 0) fail_unexpected("req", {req_we, req_addr, req_wdata});
      else begin
        check("req", {req_we, req_addr, req_wdata}, exp_req_q[0]);
        if (req_ready) void'(exp_req_q.pop_front());
      end
    end
  end

  // ---------------- bus responder ----------------
  int          ready_delay = 0;
  bit          rsp_en      = 1'b1;
  logic [31:0] rsp_data    = '0;

  initial begin
    int ready_cnt;
    bit accepted;
    ready_cnt = 0;
    accepted  = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      if (accepted) begin
        accepted = 1'b0;
        if (rsp_en) begin
          rsp_valid = 1'b1;
          rsp_rdata = rsp_data;
        end
      end
      if (req_valid) begin
        if (ready_cnt >= ready_delay) begin
          req_ready = 1'b1;
          accepted  = 1'b1;
          ready_cnt = 0;
        end else begin
          req_ready = 1'b0;
          ready_cnt++;
        end
      end else begin
        req_ready = 1'b0;
        ready_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge. Presents the op and holds it like a
  // stalled pipeline; checks stall high for n_stall cycles then low for one.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int n_stall, input int flush_cyc,
                           input string name);
    mem_rd    = rd;
    mem_wr    = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    for (int c = 0; c <= n_stall; c++) begin
      flush = (c == flush_cyc);
      @(negedge clk);
      check({name, "_stall"}, 65'(stall), 65'(c < n_stall));
      @(posedge clk);
      #1;
    end
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    flush     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state",     65'(dbg_state), 65'(0));
    check("rst_req_valid", 65'(req_valid), 65'(0));
    check("rst_req_we",    65'(req_we),    65'(0));
    check("rst_req_addr",  65'(req_addr),  65'(0));
    check("rst_req_wdata", 65'(req_wdata), 65'(0));
    check("rst_ld_data",   65'(ld_data),   65'(0));
    check("rst_ld_valid",  65'(ld_valid),  65'(0));
    check("rst_stall",     65'(stall),     65'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // lw 0x100, immediate accept, response one cycle later
    ready_delay = 0; rsp_en = 1'b1; rsp_data = 32'hDEADBEEF;
    exp_req_q.push_back({1'b0, 32'h0000_0100, 32'h0});
    exp_q.push_back({2'd1, 32'hDEADBEEF});
    do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3, -1, "lw_min");

    // sw 0x12345678 to 0x200, bus holds ready low for 3 cycles
    ready_delay = 3; rsp_data = 32'h0;
    exp_req_q.push_back({1'b1, 32'h0000_0200, 32'h1234_5678});
    do_access(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 6, -1, "sw_slow");
    ready_delay = 0;

    // misaligned lw
    exp_q.push_back({2'd2, 32'h0000_0103});
    do_access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 0, -1, "lw_misalign");

    // op killed while still in IDLE: nothing at all happens
    do_access(1'b1, 1'b0, 32'h0000_0701, 32'h0, 0, 0, "lw_flush_idle");

    // no response: timeout after the 4th WAIT_RSP cycle
    rsp_en = 1'b0;
    exp_req_q.push_back({1'b0, 32'h0000_0500, 32'h0});
    exp_q.push_back({2'd3, 32'h0});
    do_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 6, -1, "lw_timeout");
    rsp_en = 1'b1;

    // flush while waiting: transaction completes, result suppressed
    rsp_data = 32'hCAFEF00D;
    exp_req_q.push_back({1'b0, 32'h0000_0300, 32'h0});
    do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 3, 2, "lw_flush_wait");

    // back-to-back lw runs normally
    rsp_data = 32'h0BADF00D;
    exp_req_q.push_back({1'b0, 32'h0000_0304, 32'h0});
    exp_q.push_back({2'd1, 32'h0BADF00D});
    do_access(1'b1, 1'b0, 32'h0000_0304, 32'h0, 3, -1, "lw_after_flush");

    // rd and wr both high: treated as a read
    rsp_data = 32'h1122_3344;
    exp_req_q.push_back({1'b0, 32'h0000_0600, 32'h0000_0055});
    exp_q.push_back({2'd1, 32'h1122_3344});
    do_access(1'b1, 1'b1, 32'h0000_0600, 32'h0000_0055, 3, -1, "rdwr_both");

    // reset while in REQ
    ready_delay = 100;
    exp_req_q.push_back({1'b0, 32'h0000_0400, 32'h0});
    mem_rd = 1'b1; mem_addr = 32'h0000_0400; mem_wdata = 32'h0;
    @(negedge clk);
    check("rstreq_stall0", 65'(stall), 65'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("rstreq_in_req", 65'(req_valid), 65'(1));
    @(posedge clk); #1;
    reset = 1'b1; mem_rd = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstreq_state",     65'(dbg_state), 65'(0));
    check("rstreq_req_valid", 65'(req_valid), 65'(0));
    check("rstreq_stall",     65'(stall),     65'(0));
    // the request was never accepted, so it leaves the expected queue here
    if (exp_req_q.size() != 0) void'(exp_req_q.pop_front());
    @(posedge clk); #1;
    ready_delay = 0;

    // access after reset recovers
    rsp_data = 32'h89AB_CDEF;
    exp_req_q.push_back({1'b0, 32'h0000_0800, 32'h0});
    exp_q.push_back({2'd1, 32'h89AB_CDEF});
    do_access(1'b1, 1'b0, 32'h0000_0800, 32'h0, 3, -1, "lw_after_rst");

    // drain and confirm every expected item was seen
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("evt_q_empty", 65'(exp_q.size()), 65'(0));
    check("req_q_empty", 65'(exp_req_q.size()), 65'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
